// File: rtl/node_link_rx.sv
// Receiving end of the byte-serial router-to-node link: assembles four flits
// into a 32-bit packet, queues it in a small FIFO and grants credit via free.
module node_link_rx #(
  parameter int NODE_ID    = 0,
  parameter int DEPTH      = 2,
  parameter int CHECK_DEST = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        free_outbound,
  output logic [31:0] pkt_out,
  output logic        pkt_out_avail,
  input  logic        pkt_out_ack,
  output logic        proto_err,
  output logic        misroute_err,
  output logic [15:0] rx_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] NID = 4'(NODE_ID);

  typedef enum logic {IDLE, ASSEMBLE} state_t;
  state_t state, state_nx;

  logic [1:0]    cnt, cnt_nx;
  logic [7:0]    hdr, b1, b2;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          grant, complete, violation;
  logic          dest_ok, push, pop, free_nx;
  logic [31:0]   pkt_full;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    grant     = 1'b0;
    complete  = 1'b0;
    violation = 1'b0;
    case (state)
      IDLE: if (put_inbound) begin
        if (free_outbound) begin
          grant    = 1'b1;
          state_nx = ASSEMBLE;
          cnt_nx   = 2'd1;
        end else begin
          violation = 1'b1;
        end
      end
      ASSEMBLE: if (put_inbound) begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pkt_full      = {hdr, b1, b2, payload_inbound};
  assign dest_ok       = (CHECK_DEST == 0) || (hdr[3:0] == NID);
  assign pkt_out_avail = (count != '0);
  assign pop           = pkt_out_avail && pkt_out_ack;
  // Credit accounting guarantees room; the guard only protects the FIFO from a misbehaving router.
  assign push          = complete && dest_ok && ((count < CW'(DEPTH)) || pop);
  assign count_nx      = count + CW'(push) - CW'(pop);
  // Reserve a slot for the packet being assembled so one free=1 grants exactly one packet.
  assign free_nx       = ((CW+1)'(count_nx) + (CW+1)'(state_nx == ASSEMBLE)) < (CW+1)'(DEPTH);
  assign pkt_out       = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      hdr           <= 8'd0;
      b1            <= 8'd0;
      b2            <= 8'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      free_outbound <= 1'b0;
      proto_err     <= 1'b0;
      misroute_err  <= 1'b0;
      rx_count      <= 16'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      count         <= count_nx;
      free_outbound <= free_nx;
      if (grant) hdr <= payload_inbound;
      if (state == ASSEMBLE && put_inbound) begin
        if (cnt == 2'd1) b1 <= payload_inbound;
        if (cnt == 2'd2) b2 <= payload_inbound;
      end
      if (violation) proto_err <= 1'b1;
      if (complete && !dest_ok) misroute_err <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= pkt_full;
        wr_ptr      <= inc(wr_ptr);
        rx_count    <= rx_count + 16'd1;
      end
      if (pop) rd_ptr <= inc(rd_ptr);
    end
  end
endmodule

// File: tb/tb_node_link_rx.sv
// Directed bench: two receivers (destination check on/off) share one link.
module tb_node_link_rx;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        put;
  logic [7:0]  payload;
  logic        ack;

  logic        free_a, avail_a, perr_a, merr_a;
  logic [31:0] pkt_a;
  logic [15:0] rxc_a;
  logic        free_b, avail_b, perr_b, merr_b;
  logic [31:0] pkt_b;
  logic [15:0] rxc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  node_link_rx #(.NODE_ID(3), .DEPTH(2), .CHECK_DEST(1)) dut (
    .clk(clk), .rst_b(rst_b), .put_inbound(put), .payload_inbound(payload),
    .free_outbound(free_a), .pkt_out(pkt_a), .pkt_out_avail(avail_a),
    .pkt_out_ack(ack), .proto_err(perr_a), .misroute_err(merr_a), .rx_count(rxc_a));

  node_link_rx #(.NODE_ID(3), .DEPTH(2), .CHECK_DEST(0)) dut_nc (
    .clk(clk), .rst_b(rst_b), .put_inbound(put), .payload_inbound(payload),
    .free_outbound(free_b), .pkt_out(pkt_b), .pkt_out_avail(avail_b),
    .pkt_out_ack(ack), .proto_err(perr_b), .misroute_err(merr_b), .rx_count(rxc_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flit(input logic [7:0] b);
    put = 1'b1; payload = b;
    tick();
    put = 1'b0; payload = 8'h00;
  endtask

  task automatic send4(input logic [31:0] p);
    flit(p[31:24]); flit(p[23:16]); flit(p[15:8]); flit(p[7:0]);
  endtask

  task automatic pop1();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; put = 1'b0; payload = 8'h00; ack = 1'b0;
    tick(); tick();
    chk("rst_free", 32'(free_a), 32'd0);
    chk("rst_avail", 32'(avail_a), 32'd0);
    chk("rst_pkt", pkt_a, 32'd0);
    chk("rst_rxc", 32'(rxc_a), 32'd0);
    chk("rst_errs", {30'd0, perr_a, merr_a}, 32'd0);
    rst_b = 1'b0;
    #1 chk("free_before_edge", 32'(free_a), 32'd0);
    tick();
    chk("free_after_rel", 32'(free_a), 32'd1);

    // Single packet, consecutive flits
    send4(32'h23ABCDEF);
    chk("p1_avail", 32'(avail_a), 32'd1);
    chk("p1_pkt", pkt_a, 32'h23ABCDEF);
    chk("p1_rxc", 32'(rxc_a), 32'd1);
    pop1();
    chk("p1_popped", 32'(avail_a), 32'd0);
    chk("p1_free", 32'(free_a), 32'd1);

    // Fill the two-entry FIFO, then violate flow control
    send4(32'h13000001);
    chk("fill_free_after_a", 32'(free_a), 32'd1);
    flit(8'h13);
    chk("fill_free_b0", 32'(free_a), 32'd0);
    flit(8'h00); flit(8'h00); flit(8'h02);
    chk("fill_free_full", 32'(free_a), 32'd0);
    chk("fill_rxc", 32'(rxc_a), 32'd3);
    chk("fill_head", pkt_a, 32'h13000001);
    flit(8'h13);
    chk("proto_err", 32'(perr_a), 32'd1);
    chk("proto_rxc", 32'(rxc_a), 32'd3);
    chk("proto_head", pkt_a, 32'h13000001);
    tick();
    chk("hold_head", pkt_a, 32'h13000001);
    pop1();
    chk("refree", 32'(free_a), 32'd1);
    chk("second_head", pkt_a, 32'h13000002);
    chk("second_avail", 32'(avail_a), 32'd1);
    pop1();
    chk("drained", 32'(avail_a), 32'd0);
    pop1();
    chk("ack_empty_ignored", 32'(rxc_a), 32'd3);

    // Misrouted packet: dropped with the check on, delivered with it off
    send4(32'h24000001);
    chk("mis_avail", 32'(avail_a), 32'd0);
    chk("mis_err", 32'(merr_a), 32'd1);
    chk("mis_rxc", 32'(rxc_a), 32'd3);
    chk("mis_free", 32'(free_a), 32'd1);
    chk("nc_avail", 32'(avail_b), 32'd1);
    chk("nc_pkt", pkt_b, 32'h24000001);
    chk("nc_merr", 32'(merr_b), 32'd0);
    chk("nc_rxc", 32'(rxc_b), 32'd4);
    pop1();
    chk("nc_popped", 32'(avail_b), 32'd0);

    // Gapped flits
    flit(8'h13); tick(); flit(8'h11); tick(); tick(); flit(8'h22);
    chk("gap_not_yet", 32'(avail_a), 32'd0);
    flit(8'h33);
    chk("gap_avail", 32'(avail_a), 32'd1);
    chk("gap_pkt", pkt_a, 32'h13112233);
    chk("gap_rxc", 32'(rxc_a), 32'd4);
    pop1();

    // Reset mid-packet discards the partial packet
    flit(8'h13); flit(8'h55);
    rst_b = 1'b1;
    #1;
    chk("mrst_free", 32'(free_a), 32'd0);
    chk("mrst_errs", {30'd0, perr_a, merr_a}, 32'd0);
    chk("mrst_rxc", 32'(rxc_a), 32'd0);
    tick();
    rst_b = 1'b0;
    tick();
    send4(32'h13667788);
    chk("fresh_avail", 32'(avail_a), 32'd1);
    chk("fresh_pkt", pkt_a, 32'h13667788);
    chk("fresh_rxc", 32'(rxc_a), 32'd1);
    pop1();
    chk("fresh_popped", 32'(avail_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
